tag_cfg_sequencer: RTL
======================

Name: tag_cfg_sequencer

Overview:
Serial configuration master for the clock/delay generator's tag interface. It takes one-shot write requests from a local requester and serializes them as tag packets on tag_clk_o, tag_en_o and tag_data_o. It sits beside the clock/delay generator in the top wrapper and drives the tag inputs that are otherwise bonded to pads. After reset it replays a zero-preamble so the tag clients synchronize before the first packet.

Parameters:
ID_W, 4, node-id field width
LEN_W, 4, payload-length field width; max payload = 2^LEN_W-1 bits
MAX_PAYLOAD, 15, req_data_i width; must equal 2^LEN_W-1
CLK_DIV, 2, clk cycles per tag_clk half-period (>=1)
INIT_ZEROS, 32, zero bit-periods sent after reset release
GAP_BITS, 4, zero bit-periods sent after every packet

Ports:
clk  in  1  system clock, sole clock of the block
rst_n  in  1  reset, asynchronous assert, active-low
req_v_i  in  1  request valid
req_ready_o  out  1  sequencer can accept a request
req_id_i  in  ID_W  target node id
req_dnr_i  in  1  data_not_reset: 1=data write, 0=client reset
req_len_i  in  LEN_W  payload bit count, 0..MAX_PAYLOAD
req_data_i  in  MAX_PAYLOAD  payload, bit 0 sent first
tag_clk_o  out  1  serial tag clock
tag_en_o  out  1  packet-active qualifier
tag_data_o  out  1  serial tag data
busy_o  out  1  equals !req_ready_o
done_o  out  1  one-cycle pulse when a packet and its gap complete

Behaviour:
- All outputs are registered. Reset (rst_n=0), asynchronous: tag_clk_o=0, tag_en_o=0, tag_data_o=0, req_ready_o=0, busy_o=1, done_o=0, FSM=INIT, counters=0.
- Bit period: 2*CLK_DIV clk cycles. tag_clk_o is low for the first CLK_DIV cycles and high for the next CLK_DIV. tag_en_o and tag_data_o change only at the start of a low phase, so clients sample them on the tag_clk rising edge.
- INIT: tag_clk toggles, en=0, data=0, for INIT_ZEROS bit periods, then IDLE.
- IDLE: tag_clk_o=0, en=0, data=0, req_ready_o=1.
- Accept: a request is taken on the cycle req_v_i & req_ready_o. All request fields are captured. req_ready_o drops the next cycle. Inputs are ignored while not ready.
- Packet, first bit on the cycle after accept, tag_en_o=1 throughout:
  - START: 1 bit, value 1
  - ID: ID_W bits, LSB first
  - DNR: 1 bit
  - LEN: LEN_W bits, LSB first
  - PAYLOAD: req_len bits of req_data, LSB first
- req_len=0: LEN goes directly to GAP, with no payload bits.
- GAP: en=0, data=0, tag_clk keeps toggling for GAP_BITS bit periods.
- Return to IDLE: on the cycle after the last gap bit period ends, FSM=IDLE, req_ready_o=1 and done_o=1 for exactly one cycle.
- Back-to-back: a request presented with req_v_i held high is accepted on that same cycle, which is done_o's cycle. Its START bit begins on the next cycle.
- Total busy time per packet: 2*CLK_DIV*(2+ID_W+LEN_W+len+GAP_BITS) cycles. At defaults this is 4*(14+len).
- Counters: a half-period counter of width clog2(CLK_DIV)+1 and a bit counter of width clog2(max(INIT_ZEROS, MAX_PAYLOAD, GAP_BITS, ID_W, LEN_W)+1). Neither counter wraps; each reloads on every state change.
- Reset mid-packet: outputs return immediately to reset values, the packet is discarded, and INIT replays in full after rst_n rises. No done_o pulse is produced for the aborted packet.
- req_len_i > MAX_PAYLOAD cannot occur by construction. Payload bits above req_len are never sent.

Test Plan:
- Reset release, CLK_DIV=2: 32 tag_clk periods of 4 cycles each, en=0, data=0. req_ready_o rises at cycle 128 after release.
- Request id=5, dnr=1, len=3, data=0b101 -> tag_data sampled at the 13 en-high rising edges = 1,1,0,1,0,1,1,1,0,0,1,0,1. Then 4 gap bits. done_o pulses once, 68 cycles after accept.
- Request dnr=0, len=0, id=15 -> 10 en-high bits 1,1,1,1,1,0,0,0,0,0. Busy for 56 cycles.
- req_v_i held high with two queued requests -> second accepted on done_o's cycle; its START bit appears the next cycle. No idle tag_clk period between the packets beyond GAP_BITS.
- rst_n pulsed low during PAYLOAD -> en, data and tag_clk are 0 within the reset. Full 32-bit INIT replays. No done_o pulse.
- CLK_DIV=1, len=15, data=0x7FFF -> tag_clk toggles every cycle. 15 payload ones appear. Busy 2*(10+15+4)=58 cycles.

Source files
------------

// File: rtl/tag_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tag_cfg_sequencer
//  Description : Serial configuration master for the tag interface. Replays a
//                zero preamble after reset, then serializes one-shot write
//                requests as START/ID/DNR/LEN/PAYLOAD packets followed by a
//                zero gap, on tag_clk_o / tag_en_o / tag_data_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_cfg_sequencer #(
   parameter int ID_W        = 4,
   parameter int LEN_W       = 4,
   parameter int MAX_PAYLOAD = 15,
   parameter int CLK_DIV     = 2,
   parameter int INIT_ZEROS  = 32,
   parameter int GAP_BITS    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_v_i,
   output logic                   req_ready_o,
   input  logic [ID_W-1:0]        req_id_i,
   input  logic                   req_dnr_i,
   input  logic [LEN_W-1:0]       req_len_i,
   input  logic [MAX_PAYLOAD-1:0] req_data_i,
   output logic                   tag_clk_o,
   output logic                   tag_en_o,
   output logic                   tag_data_o,
   output logic                   busy_o,
   output logic                   done_o
);

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int c_half_w  = $clog2(CLK_DIV) + 1;
   localparam int c_bit_max = max_i(max_i(max_i(INIT_ZEROS, MAX_PAYLOAD),
                                          max_i(GAP_BITS, ID_W)), LEN_W);
   localparam int c_bit_w   = $clog2(c_bit_max + 1);

   localparam logic [c_half_w-1:0] c_half_last = c_half_w'(CLK_DIV - 1);
   localparam logic [c_half_w-1:0] c_half_one  = c_half_w'(1);
   localparam logic [c_bit_w-1:0]  c_bit_one   = c_bit_w'(1);
   localparam logic [c_bit_w-1:0]  c_init_last = c_bit_w'(INIT_ZEROS - 1);
   localparam logic [c_bit_w-1:0]  c_id_last   = c_bit_w'(ID_W - 1);
   localparam logic [c_bit_w-1:0]  c_len_last  = c_bit_w'(LEN_W - 1);
   localparam logic [c_bit_w-1:0]  c_gap_last  = c_bit_w'(GAP_BITS - 1);

   localparam logic [2:0] c_st_init  = 3'd0;
   localparam logic [2:0] c_st_idle  = 3'd1;
   localparam logic [2:0] c_st_start = 3'd2;
   localparam logic [2:0] c_st_id    = 3'd3;
   localparam logic [2:0] c_st_dnr   = 3'd4;
   localparam logic [2:0] c_st_len   = 3'd5;
   localparam logic [2:0] c_st_pay   = 3'd6;
   localparam logic [2:0] c_st_gap   = 3'd7;

   logic [2:0]             state_q, state_d;
   logic [c_half_w-1:0]    half_q, half_d;
   logic                   phase_q, phase_d;
   logic [c_bit_w-1:0]     bit_q, bit_d;

   logic [ID_W-1:0]        id_q;
   logic                   dnr_q;
   logic [LEN_W-1:0]       len_q;
   logic [MAX_PAYLOAD-1:0] data_q;

   logic tag_clk_q, tag_en_q, tag_data_q, ready_q, busy_q, done_q;
   logic tag_clk_d, tag_en_d, tag_data_d, ready_d, busy_d, done_d;

   logic                   w_accept;
   logic                   w_half_end;
   logic                   w_bit_end;
   logic                   w_last_bit;
   logic [2:0]             w_next_state;
   logic [c_bit_w-1:0]     w_len_ext;
   logic [ID_W-1:0]        w_id_mask;
   logic [LEN_W-1:0]       w_len_mask;
   logic [MAX_PAYLOAD-1:0] w_pay_mask;

   assign w_accept   = req_v_i & ready_q;
   assign w_half_end = (half_q == c_half_last);
   assign w_bit_end  = w_half_end & phase_q;
   assign w_len_ext  = c_bit_w'(len_q);

   // One-hot masks pick the field bit addressed by the upcoming bit index.
   assign w_id_mask  = ID_W'(1) << bit_d;
   assign w_len_mask = LEN_W'(1) << bit_d;
   assign w_pay_mask = MAX_PAYLOAD'(1) << bit_d;

   // State, counters, captured request and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= c_st_init;
         half_q     <= '0;
         phase_q    <= 1'b0;
         bit_q      <= '0;
         id_q       <= '0;
         dnr_q      <= 1'b0;
         len_q      <= '0;
         data_q     <= '0;
         tag_clk_q  <= 1'b0;
         tag_en_q   <= 1'b0;
         tag_data_q <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         half_q     <= half_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         tag_clk_q  <= tag_clk_d;
         tag_en_q   <= tag_en_d;
         tag_data_q <= tag_data_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         if (w_accept) begin
            id_q   <= req_id_i;
            dnr_q  <= req_dnr_i;
            len_q  <= req_len_i;
            data_q <= req_data_i;
         end
      end
   end

   // Next state: advance the tag clock phase and step through packet fields.
   always_comb begin
      state_d      = state_q;
      half_d       = half_q;
      phase_d      = phase_q;
      bit_d        = bit_q;
      w_last_bit   = 1'b0;
      w_next_state = c_st_idle;
      case (state_q)
         c_st_init:  begin w_last_bit = (bit_q == c_init_last); w_next_state = c_st_idle; end
         c_st_start: begin w_last_bit = 1'b1;                   w_next_state = c_st_id;   end
         c_st_id:    begin w_last_bit = (bit_q == c_id_last);   w_next_state = c_st_dnr;  end
         c_st_dnr:   begin w_last_bit = 1'b1;                   w_next_state = c_st_len;  end
         c_st_len:   begin
            w_last_bit   = (bit_q == c_len_last);
            // A zero-length request skips straight to the gap.
            w_next_state = (len_q == '0) ? c_st_gap : c_st_pay;
         end
         c_st_pay:   begin w_last_bit = (bit_q == w_len_ext - c_bit_one); w_next_state = c_st_gap; end
         c_st_gap:   begin w_last_bit = (bit_q == c_gap_last);  w_next_state = c_st_idle; end
         default:    begin w_last_bit = 1'b1;                   w_next_state = c_st_idle; end
      endcase

      if (state_q == c_st_idle) begin
         half_d  = '0;
         phase_d = 1'b0;
         bit_d   = '0;
         if (w_accept) begin
            state_d = c_st_start;
         end
      end else begin
         if (w_half_end) begin
            half_d  = '0;
            phase_d = ~phase_q;
         end else begin
            half_d = half_q + c_half_one;
         end
         if (w_bit_end) begin
            if (w_last_bit) begin
               state_d = w_next_state;
               bit_d   = '0;
            end else begin
               bit_d = bit_q + c_bit_one;
            end
         end
      end
   end

   // Output values for the next cycle, derived from the next state so every
   // output is a plain register; en/data only move when a new bit starts.
   always_comb begin
      tag_clk_d  = phase_d;
      tag_en_d   = 1'b0;
      tag_data_d = 1'b0;
      case (state_d)
         c_st_start: begin tag_en_d = 1'b1; tag_data_d = 1'b1;                  end
         c_st_id:    begin tag_en_d = 1'b1; tag_data_d = |(id_q & w_id_mask);   end
         c_st_dnr:   begin tag_en_d = 1'b1; tag_data_d = dnr_q;                 end
         c_st_len:   begin tag_en_d = 1'b1; tag_data_d = |(len_q & w_len_mask); end
         c_st_pay:   begin tag_en_d = 1'b1; tag_data_d = |(data_q & w_pay_mask); end
         default:    begin tag_en_d = 1'b0; tag_data_d = 1'b0;                  end
      endcase
      ready_d = (state_d == c_st_idle);
      busy_d  = (state_d != c_st_idle);
      done_d  = (state_q == c_st_gap) && (state_d == c_st_idle);
   end

   assign req_ready_o = ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign tag_clk_o   = tag_clk_q;
   assign tag_en_o    = tag_en_q;
   assign tag_data_o  = tag_data_q;

endmodule
`default_nettype wire
